pipe_flush_ctrl: RTL and testbench
==================================

Name: pipe_flush_ctrl

Overview:
- Parametrised pipeline flush/hold controller for the core.
- Accepts jump/redirect requests from several sources (branch unit, exception/trap, interrupt), arbitrates them by fixed priority, and broadcasts one registered redirect (flag + address) to the fetch stage.
- Drives a per-stage flush vector and a global hold for a configurable number of cycles.
- Also merges an external hold request (e.g. bus wait, multi-cycle ALU).

Parameters:
ADDR_W, 32, width of redirect addresses
NUM_SRC, 3, number of jump request sources; index 0 is highest priority
FLUSH_CYCLES, 2, cycles the redirect/flush/hold window lasts (legal 1..15)
NUM_STAGES, 3, number of pipeline stages receiving a flush bit

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
jump_req_in  in  NUM_SRC  per-source jump request level; bit i = source i
jump_addr_in  in  NUM_SRC*ADDR_W  per-source target; source i at bits [i*ADDR_W +: ADDR_W]
hold_req_in  in  1  external hold request (level)
jump_flag_out  out  1  redirect valid to fetch
jump_addr_out  out  ADDR_W  redirect target; 0 when jump_flag_out=0
flush_stage_out  out  NUM_STAGES  per-stage flush; all bits equal jump_flag_out
hold_flag_out  out  1  pipeline hold
grant_out  out  NUM_SRC  one-hot source owning current window; 0 when idle
busy_out  out  1  window active (state FLUSH)
drop_pulse_out  out  1  one-cycle pulse: an accepted-edge request was discarded

Behaviour:
- All outputs are registered. Reset is synchronous, active-high; it dominates all other inputs.
- On reset, all outputs become 0, state becomes IDLE, the counter becomes 0 and the per-source edge registers become 0.
- A request level already high when reset is released therefore counts as an edge in the first cycle after reset.
- Edge detect: per source, edge_i = jump_req_in[i] & ~req_d1[i]. req_d1 is updated every non-reset cycle. A held-high level is never re-accepted.
- Arbitration: the lowest index among asserted edge_i wins. All other edges in the same cycle are dropped, and drop_pulse_out=1 in the next cycle.
- FSM states are IDLE and FLUSH.
- IDLE -> FLUSH on any edge, evaluated at cycle N:
  - In cycle N+1: jump_flag_out=1, all flush_stage_out bits=1, hold_flag_out=1, busy_out=1, grant_out=winner, jump_addr_out=winner's address as sampled in cycle N.
  - The counter is loaded with FLUSH_CYCLES-1.
- FLUSH:
  - Outputs hold their values.
  - The counter decrements each cycle in which hold_req_in=0 and freezes while hold_req_in=1.
  - When the counter is 0 and hold_req_in=0, go to IDLE. The next cycle clears jump_flag_out, jump_addr_out (to 0), flush_stage_out, grant_out and busy_out.
  - With hold_req_in=0 throughout, the window is exactly FLUSH_CYCLES cycles.
- Preemption in FLUSH: an edge from a source with strictly higher priority than the current grant restarts the window. The counter reloads to FLUSH_CYCLES-1, and the address and grant are replaced from the next cycle.
- An edge of equal or lower priority in FLUSH is dropped (drop_pulse_out pulses). A preempted window is not reported as a drop.
- Hold:
  - hold_flag_out = busy | hold_req_in, registered (1-cycle latency from hold_req_in).
  - In IDLE with hold_req_in=1: hold_flag_out=1, jump_flag_out=0.
- Simultaneous events:
  - An edge in the last FLUSH cycle (counter 0) follows the normal priority rules.
  - If it wins, the window restarts with no idle gap.
  - If it is of lower or equal priority, it is dropped.
- Reset mid-window aborts immediately: outputs are 0 in the cycle after rst is sampled high.
- FLUSH_CYCLES=1: the window is a single cycle. The counter is then always 0.

Test Plan:
- Single jump: source 1 rises at cycle 5 with addr 0x0000_1000 (FLUSH_CYCLES=2) -> jump_flag_out/hold/flush=3'b111 in cycles 6-7, addr 0x1000, grant 3'b010; all outputs 0 in cycle 8.
- Level held: source 0 high for 10 cycles -> exactly one 2-cycle window, no second window.
- Simultaneous: sources 0 (0x100) and 2 (0x200) rise in the same cycle -> grant 3'b001, addr 0x100, drop_pulse_out=1 for one cycle.
- Preemption: source 2 window starts at cycle 10, source 0 rises at cycle 10 (first window cycle) -> addr switches to source 0's target in cycle 11, window ends after cycle 12. Source 2 rising during a source 0 window -> drop pulse, window unchanged.
- Hold extension: hold_req_in=1 during cycles 11-13 of a window starting at cycle 10 -> counter frozen, window ends after cycle 14. hold_req_in=1 in IDLE -> hold_flag_out=1, jump_flag_out=0, one-cycle lag.
- Reset mid-window: rst=1 at cycle 11 of an active window -> all outputs 0 in cycle 12. Request held high across reset release -> new window starts in the second cycle after release.

Source files
------------

// File: rtl/pipe_flush_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_flush_ctrl
//
// Pipeline flush/hold controller. Several redirect sources (branch, trap,
// interrupt, ...) raise request levels. A rising edge on a request asks for a
// redirect. The controller arbitrates simultaneous edges by fixed priority,
// where index 0 is the most urgent. It then opens a redirect window. During
// the window it broadcasts a registered redirect flag and target address to
// fetch, flushes every pipeline stage and holds the pipeline. The window
// lasts FLUSH_CYCLES cycles. An external hold request freezes the window
// countdown and is also forwarded to the pipeline hold.
//
// Ports:
//   clk              core clock
//   rst              synchronous reset, active-high, dominates everything
//   jump_req_in      per-source request level, bit i = source i
//   jump_addr_in     per-source target, source i at [i*ADDR_W +: ADDR_W]
//   hold_req_in      external hold request (level)
//   jump_flag_out    redirect valid to fetch
//   jump_addr_out    redirect target, 0 while no redirect is active
//   flush_stage_out  per-stage flush, every bit equals jump_flag_out
//   hold_flag_out    pipeline hold = registered (window active | hold_req_in)
//   grant_out        one-hot owner of the current window, 0 when idle
//   busy_out         window active
//   drop_pulse_out   one-cycle pulse: an accepted request edge was discarded
//
// FLUSH_CYCLES must lie in 1..15 so that the reload value fits the counter.
// ---------------------------------------------------------------------------
module pipe_flush_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int NUM_SRC      = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int NUM_STAGES   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        jump_req_in,
    input  logic [NUM_SRC*ADDR_W-1:0] jump_addr_in,
    input  logic                      hold_req_in,
    output logic                      jump_flag_out,
    output logic [ADDR_W-1:0]         jump_addr_out,
    output logic [NUM_STAGES-1:0]     flush_stage_out,
    output logic                      hold_flag_out,
    output logic [NUM_SRC-1:0]        grant_out,
    output logic                      busy_out,
    output logic                      drop_pulse_out
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Isolates the lowest set bit, i.e. the highest-priority requester.
    function automatic logic [NUM_SRC-1:0] lowest_one_hot(
        input logic [NUM_SRC-1:0] v
    );
        return v & ((~v) + NUM_SRC'(1));
    endfunction

    // One-hot address select; a zero select yields a zero address.
    function automatic logic [ADDR_W-1:0] select_addr(
        input logic [NUM_SRC-1:0]        sel,
        input logic [NUM_SRC*ADDR_W-1:0] addrs
    );
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel[i]) begin
                acc = acc | addrs[i*ADDR_W +: ADDR_W];
            end
        end
        return acc;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_SRC-1:0]   req_d1_q, req_d1_d;
    logic                 jump_flag_q, jump_flag_d;
    logic [ADDR_W-1:0]    jump_addr_q, jump_addr_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic                 hold_flag_q, hold_flag_d;
    logic                 drop_q, drop_d;

    logic [NUM_SRC-1:0]   edge_vec;
    logic [NUM_SRC-1:0]   win_oh;
    logic                 any_edge;
    logic                 losers;
    logic                 preempt;
    logic                 start_window;

    always_comb begin
        edge_vec = jump_req_in & ~req_d1_q;
        win_oh   = lowest_one_hot(edge_vec);
        any_edge = |edge_vec;
        losers   = |(edge_vec & ~win_oh);
        // grant_q - 1 masks every source strictly more urgent than the owner.
        preempt  = (state_q == FLUSH) && (|(win_oh & (grant_q - NUM_SRC'(1))));

        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d1_d     = jump_req_in;
        jump_flag_d  = jump_flag_q;
        jump_addr_d  = jump_addr_q;
        grant_d      = grant_q;
        drop_d       = 1'b0;
        start_window = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_edge) begin
                    start_window = 1'b1;
                end
            end
            FLUSH: begin
                if (preempt) begin
                    start_window = 1'b1;
                end else begin
                    // Equal or lower priority edges never disturb a window.
                    drop_d = any_edge;
                    if (!hold_req_in) begin
                        if (cnt_q == '0) begin
                            state_d     = IDLE;
                            jump_flag_d = 1'b0;
                            jump_addr_d = '0;
                            grant_d     = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new or preempting window; a preempted owner is not a drop.
        if (start_window) begin
            state_d     = FLUSH;
            cnt_d       = CNT_RELOAD;
            jump_flag_d = 1'b1;
            jump_addr_d = select_addr(win_oh, jump_addr_in);
            grant_d     = win_oh;
            drop_d      = losers;
        end

        hold_flag_d = (state_d == FLUSH) | hold_req_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_d1_q    <= '0;
            jump_flag_q <= 1'b0;
            jump_addr_q <= '0;
            grant_q     <= '0;
            hold_flag_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_d1_q    <= req_d1_d;
            jump_flag_q <= jump_flag_d;
            jump_addr_q <= jump_addr_d;
            grant_q     <= grant_d;
            hold_flag_q <= hold_flag_d;
            drop_q      <= drop_d;
        end
    end

    assign jump_flag_out   = jump_flag_q;
    assign jump_addr_out   = jump_addr_q;
    assign flush_stage_out = {NUM_STAGES{jump_flag_q}};
    assign hold_flag_out   = hold_flag_q;
    assign grant_out       = grant_q;
    assign busy_out        = (state_q == FLUSH);
    assign drop_pulse_out  = drop_q;

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
module tb_pipe_flush_ctrl;

    localparam int AW  = 32;
    localparam int NS  = 3;
    localparam int FC  = 2;
    localparam int NST = 3;
    localparam int VW  = 1 + AW + NST + 1 + NS + 1 + 1;

    logic              clk;
    logic              rst;
    logic [NS-1:0]     jump_req_in;
    logic [NS*AW-1:0]  jump_addr_in;
    logic              hold_req_in;
    logic              jump_flag_out;
    logic [AW-1:0]     jump_addr_out;
    logic [NST-1:0]    flush_stage_out;
    logic              hold_flag_out;
    logic [NS-1:0]     grant_out;
    logic              busy_out;
    logic              drop_pulse_out;

    int checks = 0;
    int errors = 0;

    logic [NS*AW-1:0] addr_bus;

    // Reference model: the window is described by its owner and the number
    // of window cycles still to be shown (including the current one).
    int            m_owner = -1;
    int            m_remain = 0;
    logic [AW-1:0] m_addr = '0;
    logic [NS-1:0] m_prev = '0;
    logic          m_drop = 1'b0;
    logic          m_hold = 1'b0;

    pipe_flush_ctrl #(
        .ADDR_W(AW), .NUM_SRC(NS), .FLUSH_CYCLES(FC), .NUM_STAGES(NST)
    ) dut (
        .clk(clk), .rst(rst),
        .jump_req_in(jump_req_in), .jump_addr_in(jump_addr_in),
        .hold_req_in(hold_req_in),
        .jump_flag_out(jump_flag_out), .jump_addr_out(jump_addr_out),
        .flush_stage_out(flush_stage_out), .hold_flag_out(hold_flag_out),
        .grant_out(grant_out), .busy_out(busy_out),
        .drop_pulse_out(drop_pulse_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] obs_vec();
        return {jump_flag_out, jump_addr_out, flush_stage_out, hold_flag_out,
                grant_out, busy_out, drop_pulse_out};
    endfunction

    function automatic logic [VW-1:0] mk(input logic flag, input logic [AW-1:0] a,
                                         input logic [NS-1:0] g, input logic h,
                                         input logic d);
        return {flag, a, {NST{flag}}, h, g, flag, d};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NS-1:0] g;
        logic          act;
        g = '0;
        act = (m_owner >= 0);
        if (act) g[m_owner] = 1'b1;
        return mk(act, m_addr, g, m_hold, m_drop);
    endfunction

    task automatic model_step();
        int w;
        int n;
        if (rst) begin
            m_owner = -1; m_remain = 0; m_addr = '0; m_prev = '0;
            m_drop = 1'b0; m_hold = 1'b0;
            return;
        end
        w = -1;
        n = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (jump_req_in[i] && !m_prev[i]) begin
                w = i;
                n++;
            end
        end
        if (w >= 0 && (m_owner < 0 || w < m_owner)) begin
            m_owner  = w;
            m_remain = FC;
            m_addr   = jump_addr_in[w*AW +: AW];
            m_drop   = (n > 1);
        end else begin
            m_drop = (n > 0);
            if (m_owner >= 0 && !hold_req_in) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_owner = -1;
                    m_addr  = '0;
                end
            end
        end
        m_hold = (m_owner >= 0) || hold_req_in;
        m_prev = jump_req_in;
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic step(input logic [NS-1:0] req, input logic hold, input logic r);
        jump_req_in  = req;
        jump_addr_in = addr_bus;
        hold_req_in  = hold;
        rst          = r;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        addr_bus = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            step(3'b000, 1'b1, 1'b1);
            checks++;
            if (obs_vec() !== '0) begin
                errors++;
                $display("FAIL reset_zero: got %h expected %h", obs_vec(), {VW{1'b0}});
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(3'b000, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_jump();
        addr_bus = {32'h0000_0BAD, 32'h0000_1000, 32'h0000_0DEF};
        step(3'b000, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b0);
        for (int i = 0; i < FC; i++) begin
            checks++;
            if (obs_vec() !== mk(1'b1, 32'h0000_1000, 3'b010, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL single_window: got %h expected %h", obs_vec(),
                         mk(1'b1, 32'h0000_1000, 3'b010, 1'b1, 1'b0));
            end
            step(3'b010, 1'b0, 1'b0);
        end
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL single_end: got %h expected %h", obs_vec(), {VW{1'b0}});
        end
        step(3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_level_held();
        int win_cycles;
        win_cycles = 0;
        addr_bus = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            step(3'b001, 1'b0, 1'b0);
            if (jump_flag_out === 1'b1) win_cycles++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL level_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (win_cycles !== FC) begin
            errors++;
            $display("FAIL level_once: got %0d window cycles expected %0d", win_cycles, FC);
        end
        step(3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        addr_bus = {32'h0000_0200, 32'h0000_0555, 32'h0000_0100};
        step(3'b000, 1'b0, 1'b0);
        step(3'b101, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== mk(1'b1, 32'h100, 3'b001, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL simul_first: got %h expected %h", obs_vec(),
                     mk(1'b1, 32'h100, 3'b001, 1'b1, 1'b1));
        end
        step(3'b101, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== mk(1'b1, 32'h100, 3'b001, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL simul_second: got %h expected %h", obs_vec(),
                     mk(1'b1, 32'h100, 3'b001, 1'b1, 1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            step(3'b000, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL simul_tail: got %h expected %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_preempt();
        addr_bus = {32'h0000_00C0, 32'h0000_00B0, 32'h0000_00A0};
        step(3'b100, 1'b0, 1'b0);
        checks++;
        if (grant_out !== 3'b100 || jump_addr_out !== 32'hC0) begin
            errors++;
            $display("FAIL preempt_start: got grant %b addr %h expected 100 000000c0",
                     grant_out, jump_addr_out);
        end
        step(3'b101, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== mk(1'b1, 32'hA0, 3'b001, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL preempt_switch: got %h expected %h", obs_vec(),
                     mk(1'b1, 32'hA0, 3'b001, 1'b1, 1'b0));
        end
        step(3'b101, 1'b0, 1'b0);
        step(3'b101, 1'b0, 1'b0);
        checks++;
        if (jump_flag_out !== 1'b0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL preempt_end: got flag %b busy %b expected 0 0", jump_flag_out, busy_out);
        end
        step(3'b000, 1'b0, 1'b0);
        step(3'b001, 1'b0, 1'b0);
        step(3'b101, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== mk(1'b1, 32'hA0, 3'b001, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL preempt_lowdrop: got %h expected %h", obs_vec(),
                     mk(1'b1, 32'hA0, 3'b001, 1'b1, 1'b1));
        end
        for (int i = 0; i < 3; i++) begin
            step(3'b000, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL preempt_tail: got %h expected %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        addr_bus = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        step(3'b010, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b0);
        step(3'b011, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== mk(1'b1, 32'h1000, 3'b001, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL b2b_restart: got %h expected %h", obs_vec(),
                     mk(1'b1, 32'h1000, 3'b001, 1'b1, 1'b0));
        end
        step(3'b011, 1'b0, 1'b0);
        step(3'b111, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== mk(1'b0, 32'h0, 3'b000, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL b2b_lastdrop: got %h expected %h", obs_vec(),
                     mk(1'b0, 32'h0, 3'b000, 1'b0, 1'b1));
        end
        step(3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        addr_bus = {$urandom, $urandom, $urandom};
        step(3'b010, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(3'b010, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || jump_flag_out !== 1'b1) begin
                errors++;
                $display("FAIL hold_frozen: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        step(3'b000, 1'b0, 1'b0);
        checks++;
        if (jump_flag_out !== 1'b0 || hold_flag_out !== 1'b0) begin
            errors++;
            $display("FAIL hold_end: got flag %b hold %b expected 0 0", jump_flag_out, hold_flag_out);
        end
        checks++;
        if (hold_flag_out !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle_lag: got %b expected 0", hold_flag_out);
        end
        step(3'b000, 1'b1, 1'b0);
        checks++;
        if (hold_flag_out !== 1'b1 || jump_flag_out !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: got hold %b flag %b expected 1 0", hold_flag_out, jump_flag_out);
        end
        step(3'b000, 1'b0, 1'b0);
        checks++;
        if (hold_flag_out !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle_release: got %b expected 0", hold_flag_out);
        end
    endtask

    task automatic test_reset_mid();
        addr_bus = {32'h0000_7000, 32'h0000_6000, 32'h0000_5000};
        step(3'b100, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL resetmid_abort: got %h expected %h", obs_vec(), {VW{1'b0}});
        end
        step(3'b100, 1'b0, 1'b1);
        step(3'b100, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== mk(1'b1, 32'h7000, 3'b100, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL resetmid_rearm: got %h expected %h", obs_vec(),
                     mk(1'b1, 32'h7000, 3'b100, 1'b1, 1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            step(3'b000, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL resetmid_tail: got %h expected %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [NS-1:0] req;
        logic          h;
        logic          r;
        for (int i = 0; i < 800; i++) begin
            addr_bus = {$urandom, $urandom, $urandom};
            req = NS'($urandom_range(0, 7));
            h   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 59) == 0);
            step(req, h, r);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        jump_req_in  = '0;
        jump_addr_in = '0;
        hold_req_in  = 1'b0;
        addr_bus     = '0;
        test_reset();
        test_single_jump();
        test_level_held();
        test_simultaneous();
        test_preempt();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
